// File: rtl/mips_pkg.sv
// mips_pkg: encoding constants shared by the program loader and the control
// unit decoder of the single-cycle MIPS core.
//   - funct field values for the supported R-type instructions
//   - primary opcode values (R-type, ADDI, LW, SW)
//   - loader request mnemonic codes (IN_OP)
//   - loader state encoding
//   - word-assembly helpers for the R-type and I-type formats
package mips_pkg;

  // funct field (bits 5:0) of R-type instructions
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // Primary opcode field (bits 31:26)
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // Loader request mnemonics; 8..15 are illegal
  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_SLT  = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LW   = 4'd6;
  localparam logic [3:0] OP_SW   = 4'd7;

  // Loader session state
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_DONE = 2'd2
  } load_state_e;

  // R-type word: {opcode 0, rs, rt, rd, shamt 0, funct}
  function automatic logic [31:0] r_word(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [5:0] funct);
    return {OPC_RTYPE, rs, rt, rd, 5'h00, funct};
  endfunction

  // I-type word: {opcode, rs, rt, imm}
  function automatic logic [31:0] i_word(input logic [5:0] opc, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {opc, rs, rt, imm};
  endfunction

endpackage

// File: rtl/mips_instr_pack.sv
// mips_instr_pack: combinational encoder from a symbolic request to a 32-bit
// MIPS instruction word.
// Ports:
//   op    in  4   request mnemonic (mips_pkg OP_* codes)
//   rs    in  5   source register
//   rt    in  5   second register (destination for ADDI/LW, data for SW)
//   rd    in  5   destination register, R-type only
//   imm   in  16  immediate / offset, I-type only
//   word  out 32  encoded instruction (zero when illegal)
//   legal out 1   op is one of the supported mnemonics
module mips_instr_pack
  import mips_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  // Mnemonic to instruction-word encoder
  always_comb begin
    word  = 32'h0000_0000;
    legal = 1'b1;
    case (op)
      OP_ADD:  word = r_word(rs, rt, rd, FUNCT_ADD);
      OP_SUB:  word = r_word(rs, rt, rd, FUNCT_SUB);
      OP_AND:  word = r_word(rs, rt, rd, FUNCT_AND);
      OP_OR:   word = r_word(rs, rt, rd, FUNCT_OR);
      OP_SLT:  word = r_word(rs, rt, rd, FUNCT_SLT);
      OP_ADDI: word = i_word(OPC_ADDI, rs, rt, imm);
      OP_LW:   word = i_word(OPC_LW, rs, rt, imm);
      OP_SW:   word = i_word(OPC_SW, rs, rt, imm);
      default: begin
        word  = 32'h0000_0000;
        legal = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_prog_loader.sv
// mips_prog_loader: accepts symbolic instruction requests over a valid/ready
// handshake, encodes them and writes them to consecutive instruction-memory
// word addresses through a registered write port.
// Ports:
//   CLK, RST_N           clock (rising edge), asynchronous active-low reset
//   START, FINISH        single-cycle pulses opening / closing a session
//   IN_VALID, IN_READY   request handshake
//   IN_OP/RS/RT/RD/IMM   request fields
//   IMEM_WE/ADDR/WDATA   registered instruction-memory write port
//   WORD_COUNT           words written this session (0..DEPTH)
//   BUSY, DONE           session open / session closed
//   ERR                  sticky: illegal mnemonic seen this session
module mips_prog_loader
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              START,
  input  logic              FINISH,
  input  logic              IN_VALID,
  output logic              IN_READY,
  input  logic [3:0]        IN_OP,
  input  logic [4:0]        IN_RS,
  input  logic [4:0]        IN_RT,
  input  logic [4:0]        IN_RD,
  input  logic [15:0]       IN_IMM,
  output logic              IMEM_WE,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  output logic [31:0]       IMEM_WDATA,
  output logic [ADDR_W:0]   WORD_COUNT,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_C   = {{ADDR_W{1'b0}}, 1'b1};

  load_state_e       state_r, state_s;
  logic [ADDR_W:0]   count_r, count_s;
  logic              err_r, err_s;
  logic              we_r, we_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic [31:0]       wdata_r, wdata_s;
  logic              ready_r, ready_s;
  logic              busy_r, busy_s;
  logic              done_r, done_s;
  logic [31:0]       word_s;
  logic              legal_s;
  logic              accept_s;

  mips_instr_pack u_pack (
    .op    (IN_OP),
    .rs    (IN_RS),
    .rt    (IN_RT),
    .rd    (IN_RD),
    .imm   (IN_IMM),
    .word  (word_s),
    .legal (legal_s)
  );

  // ready_r already encodes "in LOAD and not full", so no path from IN_VALID
  // or IN_OP reaches IN_READY.
  assign accept_s = IN_VALID & ready_r;

  // Next-state, counter, error and write-port logic
  always_comb begin
    state_s = state_r;
    count_s = count_r;
    err_s   = err_r;
    we_s    = 1'b0;
    addr_s  = addr_r;
    wdata_s = wdata_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        // START opens a fresh session and wins over a concurrent FINISH
        if (START) begin
          state_s = ST_LOAD;
          count_s = '0;
          err_s   = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_LOAD: begin
        if (accept_s) begin
          if (legal_s) begin
            // The count doubles as the write pointer; it never wraps.
            we_s    = 1'b1;
            addr_s  = count_r[ADDR_W-1:0];
            wdata_s = word_s;
            count_s = count_r + ONE_C;
          end else begin
            err_s   = 1'b1;
          end
        end else begin
          count_s = count_r;
        end
        if (FINISH || (count_s == DEPTH_C)) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_LOAD;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they can be registered
  // and still change in the cycle after the triggering edge.
  always_comb begin
    ready_s = (state_s == ST_LOAD) && (count_s < DEPTH_C);
    busy_s  = (state_s == ST_LOAD);
    done_s  = (state_s == ST_DONE);
  end

  // State and output registers; reset drops any pending write
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= ST_IDLE;
      count_r <= '0;
      err_r   <= 1'b0;
      we_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 32'h0000_0000;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      count_r <= count_s;
      err_r   <= err_s;
      we_r    <= we_s;
      addr_r  <= addr_s;
      wdata_r <= wdata_s;
      ready_r <= ready_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign IN_READY   = ready_r;
  assign IMEM_WE    = we_r;
  assign IMEM_ADDR  = addr_r;
  assign IMEM_WDATA = wdata_r;
  assign WORD_COUNT = count_r;
  assign BUSY       = busy_r;
  assign DONE       = done_r;
  assign ERR        = err_r;

endmodule

// File: tb/tb_mips_prog_loader.sv
// Self-checking bench for mips_prog_loader (ADDR_W=2, DEPTH=4): directed
// encoding, error, full, finish and reset scenarios followed by random traffic,
// all compared against a session-level reference model.
module tb_mips_prog_loader;

  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 4;

  logic          CLK;
  logic          RST_N;
  logic          START;
  logic          FINISH;
  logic          IN_VALID;
  logic          IN_READY;
  logic [3:0]    IN_OP;
  logic [4:0]    IN_RS;
  logic [4:0]    IN_RT;
  logic [4:0]    IN_RD;
  logic [15:0]   IN_IMM;
  logic          IMEM_WE;
  logic [AW-1:0] IMEM_ADDR;
  logic [31:0]   IMEM_WDATA;
  logic [AW:0]   WORD_COUNT;
  logic          BUSY;
  logic          DONE;
  logic          ERR;

  int checks   = 0;
  int failures = 0;

  // Reference model: session phase (0 idle, 1 loading, 2 closed)
  int          m_phase;
  int          m_count;
  bit          m_err;
  bit          m_we;
  int          m_addr;
  logic [31:0] m_data;

  mips_prog_loader #(.ADDR_W(AW)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .START      (START),
    .FINISH     (FINISH),
    .IN_VALID   (IN_VALID),
    .IN_READY   (IN_READY),
    .IN_OP      (IN_OP),
    .IN_RS      (IN_RS),
    .IN_RT      (IN_RT),
    .IN_RD      (IN_RD),
    .IN_IMM     (IN_IMM),
    .IMEM_WE    (IMEM_WE),
    .IMEM_ADDR  (IMEM_ADDR),
    .IMEM_WDATA (IMEM_WDATA),
    .WORD_COUNT (WORD_COUNT),
    .BUSY       (BUSY),
    .DONE       (DONE),
    .ERR        (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Instruction encoding from the ISA tables
  function automatic logic [31:0] encode(input int op, input int rs, input int rt,
                                         input int rd, input int imm);
    int unsigned funct_tab[5] = '{32'd32, 32'd34, 32'd36, 32'd37, 32'd42};
    int unsigned opc_tab[3]   = '{32'd8, 32'd35, 32'd43};
    int unsigned w;
    if (op < 5) w = rs * 32'd2097152 + rt * 32'd65536 + rd * 32'd2048 + funct_tab[op];
    else        w = opc_tab[op - 5] * 32'd67108864 + rs * 32'd2097152 + rt * 32'd65536 + imm;
    return w;
  endfunction

  function automatic bit m_ready();
    return (m_phase == 1) && (m_count < DEPTH);
  endfunction

  task automatic check_all(input string tag);
    check({tag, "_we"},    {31'd0, IMEM_WE}, {31'd0, m_we});
    check({tag, "_addr"},  {30'd0, IMEM_ADDR}, m_addr);
    check({tag, "_data"},  IMEM_WDATA, m_data);
    check({tag, "_count"}, {29'd0, WORD_COUNT}, m_count);
    check({tag, "_err"},   {31'd0, ERR}, {31'd0, m_err});
    check({tag, "_busy"},  {31'd0, BUSY}, {31'd0, (m_phase == 1)});
    check({tag, "_done"},  {31'd0, DONE}, {31'd0, (m_phase == 2)});
    check({tag, "_ready"}, {31'd0, IN_READY}, {31'd0, m_ready()});
  endtask

  task automatic model_reset();
    m_phase = 0; m_count = 0; m_err = 1'b0; m_we = 1'b0; m_addr = 0; m_data = 32'd0;
  endtask

  // One clock: apply inputs, advance model, check all outputs after the edge
  task automatic cyc(input string tag, input bit st, input bit fi, input bit va,
                     input int op, input int rs, input int rt, input int rd, input int imm);
    bit acc;
    START = st; FINISH = fi; IN_VALID = va;
    IN_OP = op[3:0]; IN_RS = rs[4:0]; IN_RT = rt[4:0]; IN_RD = rd[4:0]; IN_IMM = imm[15:0];
    acc  = va && m_ready();
    m_we = 1'b0;
    if (m_phase != 1) begin
      if (st) begin m_phase = 1; m_count = 0; m_err = 1'b0; end
    end else begin
      if (acc) begin
        if (op < 8) begin
          m_we = 1'b1; m_addr = m_count; m_data = encode(op, rs, rt, rd, imm);
          m_count++;
        end else begin
          m_err = 1'b1;
        end
      end
      if (fi || m_count == DEPTH) m_phase = 2;
    end
    @(posedge CLK);
    #1;
    check_all(tag);
    START = 1'b0; FINISH = 1'b0; IN_VALID = 1'b0;
  endtask

  task automatic idle(input string tag);
    cyc(tag, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic start_s(input string tag);
    cyc(tag, 1'b1, 1'b0, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic finish_s(input string tag);
    cyc(tag, 1'b0, 1'b1, 1'b0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    START = 1'b0; FINISH = 1'b0; IN_VALID = 1'b0;
    IN_OP = 4'd0; IN_RS = 5'd0; IN_RT = 5'd0; IN_RD = 5'd0; IN_IMM = 16'd0;
    RST_N = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge CLK);
    RST_N = 1'b1;
    idle("idle");

    // Encodings, one session each
    start_s("enc_start");
    cyc("enc_add", 1'b0, 1'b0, 1'b1, 0, 1, 2, 3, 0);
    check("add_word", IMEM_WDATA, 32'h0022_1820);
    check("add_addr", {30'd0, IMEM_ADDR}, 32'd0);
    finish_s("enc_fin1");
    start_s("enc_start2");
    cyc("enc_lw", 1'b0, 1'b0, 1'b1, 6, 4, 5, 0, 16'h0010);
    check("lw_word", IMEM_WDATA, 32'h8C85_0010);
    idle("enc_hold");
    check("hold_word", IMEM_WDATA, 32'h8C85_0010);
    finish_s("enc_fin2");
    start_s("enc_start3");
    cyc("enc_sw", 1'b0, 1'b0, 1'b1, 7, 4, 5, 0, 16'h0010);
    check("sw_word", IMEM_WDATA, 32'hAC85_0010);
    finish_s("enc_fin3");
    start_s("enc_start4");
    cyc("enc_addi", 1'b0, 1'b0, 1'b1, 5, 0, 8, 0, 16'hFFFF);
    check("addi_word", IMEM_WDATA, 32'h2008_FFFF);
    finish_s("enc_fin4");

    // Illegal mnemonic between two ADDs
    start_s("ill_start");
    cyc("ill_add1", 1'b0, 1'b0, 1'b1, 0, 1, 2, 3, 0);
    cyc("ill_bad", 1'b0, 1'b0, 1'b1, 15, 1, 2, 3, 0);
    check("ill_err", {31'd0, ERR}, 32'd1);
    check("ill_nowe", {31'd0, IMEM_WE}, 32'd0);
    cyc("ill_add2", 1'b0, 1'b0, 1'b1, 0, 1, 2, 3, 0);
    check("ill_addr", {30'd0, IMEM_ADDR}, 32'd1);
    check("ill_count", {29'd0, WORD_COUNT}, 32'd2);
    finish_s("ill_fin");

    // Full: IN_VALID held high
    start_s("full_start");
    for (int i = 0; i < 5; i++) begin
      cyc("full", 1'b0, 1'b0, 1'b1, 0, i, i + 1, i + 2, 0);
      if (i < 4) check("full_addr", {30'd0, IMEM_ADDR}, i);
    end
    check("full_5th_nowe", {31'd0, IMEM_WE}, 32'd0);
    check("full_ready", {31'd0, IN_READY}, 32'd0);
    check("full_done", {31'd0, DONE}, 32'd1);
    check("full_count", {29'd0, WORD_COUNT}, 32'd4);

    // FINISH with concurrent accept, then restart
    start_s("fin_start");
    cyc("fin_sub", 1'b0, 1'b1, 1'b1, 1, 1, 2, 3, 0);
    check("fin_word", IMEM_WDATA, 32'h0022_1822);
    check("fin_done", {31'd0, DONE}, 32'd1);
    cyc("fin_restart", 1'b1, 1'b1, 1'b0, 0, 0, 0, 0, 0);
    check("restart_count", {29'd0, WORD_COUNT}, 32'd0);
    cyc("restart_add", 1'b0, 1'b0, 1'b1, 2, 7, 8, 9, 0);
    check("restart_addr", {30'd0, IMEM_ADDR}, 32'd0);

    // Reset between an accept and its write
    cyc("rst_acc1", 1'b0, 1'b0, 1'b1, 3, 3, 4, 5, 0);
    IN_VALID = 1'b1; IN_OP = 4'd0;
    #3;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    @(posedge CLK);
    #1;
    IN_VALID = 1'b0;
    check_all("rst_held");
    @(negedge CLK);
    RST_N = 1'b1;
    idle("rst_idle");
    start_s("rst_start");
    cyc("rst_add", 1'b0, 1'b0, 1'b1, 0, 1, 2, 3, 0);
    check("rst_addr", {30'd0, IMEM_ADDR}, 32'd0);

    // Random traffic
    for (int n = 0; n < 800; n++) begin
      int op;
      op = ($urandom_range(0, 3) == 0) ? $urandom_range(8, 15) : $urandom_range(0, 7);
      cyc("rand", ($urandom_range(0, 15) == 0), ($urandom_range(0, 11) == 0),
          ($urandom_range(0, 3) != 0), op, $urandom_range(0, 31), $urandom_range(0, 31),
          $urandom_range(0, 31), $urandom_range(0, 65535));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
